// File: rtl/div_issue_ctrl.sv
// RV32M divide issue control: special cases, divider launch, flush drain.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid_i,
  input  logic          is_div_i,
  input  logic [2:0]    funct3_i,
  input  logic [DW-1:0] rs1_i,
  input  logic [DW-1:0] rs2_i,
  input  logic [4:0]    rd_i,
  input  logic          flush_i,
  output logic [DW-1:0] div_dividend_o,
  output logic [DW-1:0] div_divisor_o,
  output logic          div_signed_o,
  output logic          div_en_o,
  input  logic [DW-1:0] div_quot_i,
  input  logic [DW-1:0] div_rem_i,
  input  logic          div_done_i,
  output logic          stall_o,
  output logic          wb_valid_o,
  output logic [4:0]    wb_rd_o,
  output logic [DW-1:0] wb_data_o,
  output logic          err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] MIN  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          sel_rem;

  logic          accept;
  logic          sgn_in;
  logic          rem_in;
  logic          zero_div;
  logic          ovf;
  logic          special;
  logic [DW-1:0] special_data;
  logic          timeout;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          unused_f3;

  // is_div_i already implies funct3[2]
  assign unused_f3 = funct3_i[2];

  assign accept = (state == S_IDLE) & ex_valid_i
                & is_div_i & ~flush_i;
  assign sgn_in = ~funct3_i[0];
  assign rem_in = funct3_i[1];

  assign zero_div = (rs2_i == '0);
  assign ovf      = sgn_in & (rs1_i == MIN)
                  & (rs2_i == ONES);
  assign special  = zero_div | ovf;

  always_comb begin
    special_data = '0;
    if (zero_div)
      special_data = rem_in ? rs1_i : ONES;
    else
      special_data = rem_in ? '0 : rs1_i;
  end

  assign timeout = (cnt == CW'(TIMEOUT - 1));

`ifdef DIV_RESULT_CACHE_EN
  logic          c_valid;
  logic [DW-1:0] c_rs1;
  logic [DW-1:0] c_rs2;
  logic          c_sgn;
  logic [DW-1:0] c_quot;
  logic [DW-1:0] c_rem;
  logic          c_fill;

  assign hit = c_valid & (c_rs1 == rs1_i)
             & (c_rs2 == rs2_i) & (c_sgn == sgn_in);
  assign hit_data = rem_in ? c_rem : c_quot;
  assign c_fill = (state == S_WAIT) & div_done_i
                & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_sgn   <= 1'b0;
      c_quot  <= '0;
      c_rem   <= '0;
    end else if (c_fill) begin
      c_valid <= 1'b1;
      c_rs1   <= div_dividend_o;
      c_rs2   <= div_divisor_o;
      c_sgn   <= div_signed_o;
      c_quot  <= div_quot_i;
      c_rem   <= div_rem_i;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      sel_rem        <= 1'b0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_signed_o   <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      err_o          <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            wb_rd_o        <= rd_i;
            sel_rem        <= rem_in;
            div_dividend_o <= rs1_i;
            div_divisor_o  <= rs2_i;
            div_signed_o   <= sgn_in;
            if (special) begin
              wb_data_o <= special_data;
              state     <= S_DONE;
            end else if (hit) begin
              wb_data_o <= hit_data;
              state     <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= flush_i ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (div_done_i) begin
            if (flush_i) begin
              state <= S_IDLE;
            end else begin
              wb_data_o <= sel_rem ? div_rem_i
                                   : div_quot_i;
              state     <= S_DONE;
            end
          end else if (flush_i) begin
            state <= S_DRAIN;
          end else if (timeout) begin
            wb_data_o <= '0;
            err_o     <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DRAIN: begin
          cnt <= cnt + 1'b1;
          if (div_done_i) begin
            state <= S_IDLE;
          end else if (timeout) begin
            err_o <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_en_o   = (state == S_ISSUE);
  assign wb_valid_o = (state == S_DONE) & ~flush_i;

  always_comb begin
    stall_o = 1'b0;
    case (state)
      S_IDLE:  stall_o = accept;
      S_ISSUE: stall_o = 1'b1;
      S_WAIT:  stall_o = 1'b1;
      S_DRAIN: stall_o = ex_valid_i & is_div_i;
      default: stall_o = 1'b0;
    endcase
  end

endmodule
